calc_entry_fsm: RTL and testbench
=================================

// Module: calc_entry_fsm
// PURPOSE
//  Parametrised keypad-entry/sequencing controller for the FPGA calculator, NDIG BCD digits wide.
//  Collects operand A, operator, operand B from a 4-bit key strobe; drives the ALU over a start/done handshake.
//  Shows A, B, result or error on the BCD display bus. Fully synchronous to clk; key_valid is a 1-cycle strobe.
// PARAMETERS
//  NDIG        4   number of BCD digits per operand/result (W = 4*NDIG bits)
//  TIMEOUT_CYC 64  cycles CALC waits for alu_done before entering ERROR
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  reset      in   1  asynchronous, active-high
//  key_valid  in   1  one-cycle strobe: key_code valid
//  key_code   in   4  0-9 digit, 10 '=', 11 AC, 12 '+', 13 '-', 14 '*', 15 '/'
//  alu_res    in   W  BCD result, valid when alu_done=1
//  alu_done   in   1  one-cycle ALU completion strobe
//  alu_err    in   1  qualifies alu_done: overflow / divide-by-zero
//  alu_a      out  W  operand A (registered)
//  alu_b      out  W  operand B (registered)
//  alu_op     out  4  latched operator code (12-15; 0 when none)
//  alu_start  out  1  one-cycle pulse; alu_a/b/op stable from that cycle until alu_done
//  display    out  W  BCD digits to display driver (registered)
//  err        out  1  high while in ERROR
//  state      out  3  current state encoding (debug)
// BEHAVIOUR
//  Reset: A=B=R=0, alu_op=0, digit counts=0, alu_start=0, err=0, display=0, state=ENTER_A.
//  States: ENTER_A=0, ENTER_B=1, CALC=2, SHOW=3, ERROR=4. Keys handled in cycle after key_valid.
//  Digit entry: value = {value[W-5:0], key}; count++ if count<NDIG, else key ignored (no wrap);
//   '0' into value 0 does not advance count.
//  ENTER_A: digit->A; AC->A=0; op->alu_op=key, B=0, ENTER_B; '=' ignored.
//  ENTER_B: digit->B; '='->alu_start=1, CALC; AC with B count>0 -> B=0, stay;
//   AC with B count=0 -> clear A,B,op, ENTER_A; op -> see CONFIGURATION.
//  CALC: all keys dropped, including a key in same cycle as alu_done. Timeout counter cleared on entry.
//   alu_done&!alu_err -> R=alu_res, SHOW; alu_done&alu_err -> ERROR; TIMEOUT_CYC cycles w/o done -> ERROR.
//  SHOW: digit -> A={0,key}, B=0, op=0, ENTER_A; op -> A=R, alu_op=key, B=0, ENTER_B;
//   '=' -> A=R, keep B/op, alu_start, CALC (repeat last op); AC -> full clear, ENTER_A.
//  ERROR: err=1; only AC leaves (full clear, ENTER_A); all other keys ignored.
//  alu_done outside CALC ignored. Reset mid-CALC aborts: alu_start low, later alu_done ignored.
//  Display, 1-cycle latency after register update: ENTER_A->A; ENTER_B->B, or A while B count=0;
//   CALC->hold previous; SHOW->R; ERROR->{NDIG{4'hE}}.
//  Latency: '=' key -> alu_start 1 cycle; alu_done -> display=R 2 cycles.
// CONFIGURATION
//  CALC_CHAIN_EN defined: op key in ENTER_B with B count>0 -> alu_start, CALC, key saved as pending op;
//   on good done: A=alu_res, alu_op=pending, B=0, ENTER_B (display shows A). Error/timeout -> ERROR.
//   op key with B count=0 replaces alu_op.
//  CALC_CHAIN_EN undefined: op key in ENTER_B only replaces alu_op (operator correction), no ALU start.
// TESTING
//  1) keys 1,2,+,3,=; alu_done 3 cyc later, res 0x0015 -> alu_a=0x0012, alu_b=0x0003,
//     alu_op=12, single alu_start, state SHOW, display 0x0015.
//  2) NDIG=4, keys 0,0,1,2,3,4,5 -> A=0x1234, display 0x1234; '5' dropped.
//  3) 7,*,4,AC -> B=0, ENTER_B; AC again -> ENTER_A, A=0, alu_op=0, display 0.
//  4) 9,/,0,=, no alu_done -> ERROR after 64 cycles, err=1, display 0xEEEE;
//     digit ignored; AC -> ENTER_A, err=0.
//  5) after test 1 SHOW, '=' -> alu_a=0x0015, alu_b=0x0003, alu_op=12, alu_start; reset mid-CALC -> all zero.
//  6) 2,+,3,* : with CALC_CHAIN_EN, done res 0x0005 -> ENTER_B, alu_a=0x0005, alu_op=14;
//     without it -> alu_op=14, B=0x0003, no alu_start.

Source files
------------

// File: rtl/calc_entry_fsm.sv
// calc_entry_fsm: keypad entry and ALU sequencing controller for the NDIG-digit BCD calculator.
// Optional operator chaining in ENTER_B is built when CALC_CHAIN_EN is defined.
module calc_entry_fsm #(
    parameter int NDIG        = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic [4*NDIG-1:0] alu_res,
    input  logic              alu_done,
    input  logic              alu_err,
    output logic [4*NDIG-1:0] alu_a,
    output logic [4*NDIG-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_start,
    output logic [4*NDIG-1:0] display,
    output logic              err,
    output logic [2:0]        state
);
    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NDIG);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        CALC    = 3'd2,
        SHOW    = 3'd3,
        ERROR   = 3'd4
    } state_t;

    state_t        st;
    logic [W-1:0]  r_reg;
    logic [CW-1:0] cnt_a, cnt_b;
    logic [TW-1:0] tmo_cnt;
`ifdef CALC_CHAIN_EN
    logic          pend_vld;
    logic [3:0]    pend_op;
`endif

    logic is_digit, is_eq, is_ac, is_op;
    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_eq    = key_valid && (key_code == 4'd10);
    assign is_ac    = key_valid && (key_code == 4'd11);
    assign is_op    = key_valid && (key_code >= 4'd12);
    assign state    = st;

    // Leading zeros are not counted so "0,0,1,2,3,4" still fills all digits.
    function automatic logic digit_accept(input logic [W-1:0] v, input logic [CW-1:0] c,
                                          input logic [3:0] d);
        return (c < CNT_MAX) && !((v == '0) && (d == 4'd0));
    endfunction

    function automatic logic [W-1:0] push_digit(input logic [W-1:0] v, input logic [3:0] d);
        return (v << 4) | W'(d);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= ENTER_A;
            alu_a     <= '0;
            alu_b     <= '0;
            r_reg     <= '0;
            alu_op    <= 4'd0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            tmo_cnt   <= '0;
            alu_start <= 1'b0;
            err       <= 1'b0;
            display   <= '0;
`ifdef CALC_CHAIN_EN
            pend_vld  <= 1'b0;
            pend_op   <= 4'd0;
`endif
        end else begin
            alu_start <= 1'b0;

            // Display trails the operand/result registers by one cycle.
            case (st)
                ENTER_A: display <= alu_a;
                ENTER_B: display <= (cnt_b == '0) ? alu_a : alu_b;
                SHOW:    display <= r_reg;
                ERROR:   display <= {NDIG{4'hE}};
                default: display <= display;
            endcase

            case (st)
                ENTER_A: begin
                    if (is_digit) begin
                        if (digit_accept(alu_a, cnt_a, key_code)) begin
                            alu_a <= push_digit(alu_a, key_code);
                            cnt_a <= cnt_a + 1'b1;
                        end
                    end else if (is_ac) begin
                        alu_a <= '0;
                        cnt_a <= '0;
                    end else if (is_op) begin
                        alu_op <= key_code;
                        alu_b  <= '0;
                        cnt_b  <= '0;
                        st     <= ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_digit) begin
                        if (digit_accept(alu_b, cnt_b, key_code)) begin
                            alu_b <= push_digit(alu_b, key_code);
                            cnt_b <= cnt_b + 1'b1;
                        end
                    end else if (is_eq) begin
                        alu_start <= 1'b1;
                        tmo_cnt   <= '0;
                        st        <= CALC;
`ifdef CALC_CHAIN_EN
                        pend_vld  <= 1'b0;
`endif
                    end else if (is_ac) begin
                        alu_b <= '0;
                        cnt_b <= '0;
                        if (cnt_b == '0) begin
                            alu_a  <= '0;
                            cnt_a  <= '0;
                            alu_op <= 4'd0;
                            st     <= ENTER_A;
                        end
                    end else if (is_op) begin
`ifdef CALC_CHAIN_EN
                        if (cnt_b != '0) begin
                            alu_start <= 1'b1;
                            tmo_cnt   <= '0;
                            pend_vld  <= 1'b1;
                            pend_op   <= key_code;
                            st        <= CALC;
                        end else begin
                            alu_op <= key_code;
                        end
`else
                        alu_op <= key_code;
`endif
                    end
                end
                CALC: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (alu_done && !alu_err) begin
`ifdef CALC_CHAIN_EN
                        if (pend_vld) begin
                            alu_a    <= alu_res;
                            alu_op   <= pend_op;
                            alu_b    <= '0;
                            cnt_b    <= '0;
                            pend_vld <= 1'b0;
                            st       <= ENTER_B;
                        end else begin
                            r_reg <= alu_res;
                            st    <= SHOW;
                        end
`else
                        r_reg <= alu_res;
                        st    <= SHOW;
`endif
                    end else if (alu_done || (tmo_cnt == TMO_LAST)) begin
                        err <= 1'b1;
                        st  <= ERROR;
`ifdef CALC_CHAIN_EN
                        pend_vld <= 1'b0;
`endif
                    end
                end
                SHOW: begin
                    if (is_digit) begin
                        alu_a  <= W'(key_code);
                        cnt_a  <= (key_code != 4'd0) ? CW'(1) : '0;
                        alu_b  <= '0;
                        cnt_b  <= '0;
                        alu_op <= 4'd0;
                        st     <= ENTER_A;
                    end else if (is_op) begin
                        alu_a  <= r_reg;
                        cnt_a  <= CNT_MAX;
                        alu_op <= key_code;
                        alu_b  <= '0;
                        cnt_b  <= '0;
                        st     <= ENTER_B;
                    end else if (is_eq) begin
                        alu_a     <= r_reg;
                        alu_start <= 1'b1;
                        tmo_cnt   <= '0;
                        st        <= CALC;
                    end else if (is_ac) begin
                        alu_a  <= '0;
                        alu_b  <= '0;
                        r_reg  <= '0;
                        alu_op <= 4'd0;
                        cnt_a  <= '0;
                        cnt_b  <= '0;
                        st     <= ENTER_A;
                    end
                end
                ERROR: begin
                    if (is_ac) begin
                        alu_a  <= '0;
                        alu_b  <= '0;
                        r_reg  <= '0;
                        alu_op <= 4'd0;
                        cnt_a  <= '0;
                        cnt_b  <= '0;
                        err    <= 1'b0;
                        st     <= ENTER_A;
                    end
                end
                default: st <= ENTER_A;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: directed scenarios plus randomized keys/ALU replies against a decimal-level model.
module tb_calc_entry_fsm;
    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;
    localparam int TMO  = 64;
    localparam int S_A = 0, S_B = 1, S_CALC = 2, S_SHOW = 3, S_ERR = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         key_valid = 1'b0;
    logic [3:0]   key_code = 4'd0;
    logic [W-1:0] alu_res = '0;
    logic         alu_done = 1'b0;
    logic         alu_err = 1'b0;
    logic [W-1:0] alu_a, alu_b, display;
    logic [3:0]   alu_op;
    logic         alu_start, err;
    logic [2:0]   state;

    always #5 clk = ~clk;

    calc_entry_fsm #(.NDIG(NDIG), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .alu_res(alu_res), .alu_done(alu_done), .alu_err(alu_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .display(display), .err(err), .state(state)
    );

    int checks = 0, errors = 0, starts = 0;

    // Reference model: operands held as decimal integers plus digit counts.
    int m_a, m_ac, m_b, m_bc, m_op, m_st, m_wait, m_pend, m_pop;
    logic [W-1:0] m_r, m_disp;
    logic m_start, m_err;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int to_dec(input logic [W-1:0] b);
        int v = 0;
        for (int i = NDIG - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    task automatic model_reset();
        m_a = 0; m_ac = 0; m_b = 0; m_bc = 0; m_op = 0; m_st = S_A; m_wait = 0;
        m_pend = 0; m_pop = 0; m_r = '0; m_disp = '0; m_start = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_digit(inout int v, inout int c, input int d);
        if (c < NDIG && !(v == 0 && d == 0)) begin
            v = v * 10 + d;
            c++;
        end
    endtask

    task automatic model_clear();
        m_a = 0; m_ac = 0; m_b = 0; m_bc = 0; m_op = 0; m_st = S_A;
    endtask

    task automatic model_calc();
        m_start = 1'b1; m_wait = 0; m_st = S_CALC;
    endtask

    task automatic model_step();
        int  k = int'(key_code);
        bit  dig = key_valid && k <= 9;
        bit  eq  = key_valid && k == 10;
        bit  ac  = key_valid && k == 11;
        bit  op  = key_valid && k >= 12;
        if (m_st == S_A) m_disp = to_bcd(m_a);
        else if (m_st == S_B) m_disp = (m_bc == 0) ? to_bcd(m_a) : to_bcd(m_b);
        else if (m_st == S_SHOW) m_disp = m_r;
        else if (m_st == S_ERR) m_disp = {NDIG{4'hE}};
        m_start = 1'b0;
        case (m_st)
            S_A: begin
                if (dig) model_digit(m_a, m_ac, k);
                else if (ac) begin m_a = 0; m_ac = 0; end
                else if (op) begin m_op = k; m_b = 0; m_bc = 0; m_st = S_B; end
            end
            S_B: begin
                if (dig) model_digit(m_b, m_bc, k);
                else if (eq) begin m_pend = 0; model_calc(); end
                else if (ac) begin
                    if (m_bc > 0) begin m_b = 0; m_bc = 0; end
                    else model_clear();
                end else if (op) begin
`ifdef CALC_CHAIN_EN
                    if (m_bc > 0) begin m_pend = 1; m_pop = k; model_calc(); end
                    else m_op = k;
`else
                    m_op = k;
`endif
                end
            end
            S_CALC: begin
                m_wait++;
                if (alu_done && !alu_err) begin
                    if (m_pend != 0) begin
                        m_a = to_dec(alu_res); m_op = m_pop; m_b = 0; m_bc = 0;
                        m_pend = 0; m_st = S_B;
                    end else begin
                        m_r = alu_res; m_st = S_SHOW;
                    end
                end else if (alu_done || m_wait == TMO) begin
                    m_pend = 0; m_st = S_ERR;
                end
            end
            S_SHOW: begin
                if (dig) begin
                    m_a = k; m_ac = (k != 0) ? 1 : 0; m_b = 0; m_bc = 0; m_op = 0; m_st = S_A;
                end else if (op) begin
                    m_a = to_dec(m_r); m_op = k; m_b = 0; m_bc = 0; m_st = S_B;
                end else if (eq) begin
                    m_a = to_dec(m_r); model_calc();
                end else if (ac) model_clear();
            end
            default: if (ac) model_clear();
        endcase
        m_err = (m_st == S_ERR);
    endtask

    task automatic cycle();
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        if (alu_start) starts++;
    endtask

    task automatic do_reset();
        reset = 1'b1; key_valid = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();
        starts = 0;
    endtask

    task automatic press(input int k);
        key_valid = 1'b1; key_code = 4'(k);
        cycle();
        key_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [W-1:0] res, input logic e);
        alu_done = 1'b1; alu_res = res; alu_err = e;
        cycle();
        alu_done = 1'b0; alu_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        checks++;
        if ({state, alu_a, alu_b, alu_op, alu_start, err, display} !== '0) begin
            errors++;
            $display("FAIL reset: st=%0d a=%h b=%h op=%0d start=%b err=%b disp=%h, want all zero",
                     state, alu_a, alu_b, alu_op, alu_start, err, display);
        end
        do_reset();
    endtask

    task automatic basic_sequence();
        press(1); press(2); press(12); press(3); press(10);
        cycle(); cycle();
        pulse_done(16'h0015, 1'b0);
        cycle();
    endtask

    task automatic test_basic();
        do_reset();
        basic_sequence();
        checks++;
        if (alu_a !== 16'h0012 || alu_b !== 16'h0003 || alu_op !== 4'd12) begin
            errors++;
            $display("FAIL basic_operands: a=%h b=%h op=%0d, want 0012 0003 12", alu_a, alu_b, alu_op);
        end
        checks++;
        if (starts != 1) begin
            errors++; $display("FAIL basic_starts: got %0d want 1", starts);
        end
        checks++;
        if (state !== 3'd3 || display !== 16'h0015) begin
            errors++; $display("FAIL basic_show: st=%0d disp=%h, want 3 0015", state, display);
        end
    endtask

    task automatic test_digit_limit();
        do_reset();
        press(0); press(0); press(1); press(2); press(3); press(4); press(5);
        cycle();
        checks++;
        if (alu_a !== 16'h1234 || display !== 16'h1234 || state !== 3'd0) begin
            errors++;
            $display("FAIL digit_limit: a=%h disp=%h st=%0d, want 1234 1234 0", alu_a, display, state);
        end
    endtask

    task automatic test_clear();
        do_reset();
        press(7); press(14); press(4); press(11);
        cycle();
        checks++;
        if (alu_b !== '0 || state !== 3'd1 || display !== 16'h0007) begin
            errors++;
            $display("FAIL clear_b: b=%h st=%0d disp=%h, want 0000 1 0007", alu_b, state, display);
        end
        press(11);
        cycle();
        checks++;
        if (state !== 3'd0 || alu_a !== '0 || alu_op !== 4'd0 || display !== '0) begin
            errors++;
            $display("FAIL clear_all: st=%0d a=%h op=%0d disp=%h, want 0 0000 0 0000",
                     state, alu_a, alu_op, display);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        press(9); press(15); press(0); press(10);
        for (int i = 0; i < 60; i++) cycle();
        checks++;
        if (state !== 3'd2) begin
            errors++; $display("FAIL timeout_early: st=%0d want 2", state);
        end
        for (int i = 0; i < 10 && state !== 3'd4; i++) cycle();
        cycle();
        checks++;
        if (state !== 3'd4 || err !== 1'b1 || display !== 16'hEEEE) begin
            errors++;
            $display("FAIL timeout_error: st=%0d err=%b disp=%h, want 4 1 EEEE", state, err, display);
        end
        press(5);
        cycle();
        checks++;
        if (state !== 3'd4 || err !== 1'b1) begin
            errors++; $display("FAIL error_hold: st=%0d err=%b, want 4 1", state, err);
        end
        press(11);
        cycle();
        checks++;
        if (state !== 3'd0 || err !== 1'b0) begin
            errors++; $display("FAIL error_exit: st=%0d err=%b, want 0 0", state, err);
        end
    endtask

    task automatic test_repeat();
        do_reset();
        basic_sequence();
        press(10);
        checks++;
        if (alu_a !== 16'h0015 || alu_b !== 16'h0003 || alu_op !== 4'd12 || alu_start !== 1'b1) begin
            errors++;
            $display("FAIL repeat: a=%h b=%h op=%0d start=%b, want 0015 0003 12 1",
                     alu_a, alu_b, alu_op, alu_start);
        end
        cycle();
        reset = 1'b1;
        #1;
        checks++;
        if ({state, alu_a, alu_b, alu_op, alu_start, err, display} !== '0) begin
            errors++;
            $display("FAIL abort_reset: st=%0d a=%h b=%h op=%0d start=%b disp=%h, want all zero",
                     state, alu_a, alu_b, alu_op, alu_start, display);
        end
        cycle();
        reset = 1'b0;
        cycle();
        pulse_done(16'h0099, 1'b0);
        cycle();
        checks++;
        if (state !== 3'd0 || display !== '0) begin
            errors++; $display("FAIL late_done: st=%0d disp=%h, want 0 0000", state, display);
        end
    endtask

    task automatic test_chain();
        do_reset();
        press(2); press(12); press(3); press(14);
`ifdef CALC_CHAIN_EN
        checks++;
        if (alu_start !== 1'b1 || state !== 3'd2) begin
            errors++; $display("FAIL chain_start: start=%b st=%0d, want 1 2", alu_start, state);
        end
        cycle();
        pulse_done(16'h0005, 1'b0);
        cycle();
        checks++;
        if (state !== 3'd1 || alu_a !== 16'h0005 || alu_op !== 4'd14 || display !== 16'h0005) begin
            errors++;
            $display("FAIL chain_done: st=%0d a=%h op=%0d disp=%h, want 1 0005 14 0005",
                     state, alu_a, alu_op, display);
        end
`else
        cycle();
        checks++;
        if (alu_op !== 4'd14 || alu_b !== 16'h0003 || starts != 0 || state !== 3'd1) begin
            errors++;
            $display("FAIL op_replace: op=%0d b=%h starts=%0d st=%0d, want 14 0003 0 1",
                     alu_op, alu_b, starts, state);
        end
`endif
    endtask

    task automatic test_random();
        int alu_cd = 0;
        int r;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            checks++;
            if ({state, alu_a, alu_b, alu_op, alu_start, display, err} !==
                {3'(m_st), to_bcd(m_a), to_bcd(m_b), 4'(m_op), m_start, m_disp, m_err}) begin
                errors++;
                $display("FAIL random cyc %0d: got st=%0d a=%h b=%h op=%0d start=%b disp=%h err=%b, want st=%0d a=%h b=%h op=%0d start=%b disp=%h err=%b",
                         n, state, alu_a, alu_b, alu_op, alu_start, display, err,
                         m_st, to_bcd(m_a), to_bcd(m_b), m_op, m_start, m_disp, m_err);
            end
            if (alu_start) alu_cd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            alu_done = (alu_cd == 1) || ($urandom_range(0, 59) == 0);
            if (alu_cd > 0) alu_cd--;
            alu_err   = ($urandom_range(0, 7) == 0);
            alu_res   = to_bcd(int'($urandom_range(0, 9999)));
            key_valid = ($urandom_range(0, 2) == 0);
            r = int'($urandom_range(0, 19));
            key_code = 4'(r < 10 ? r : r < 14 ? r + 2 : r < 17 ? 10 : r == 17 ? 11 : r - 18);
            cycle();
        end
        key_valid = 1'b0;
        alu_done  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_digit_limit();
        test_clear();
        test_timeout();
        test_repeat();
        test_chain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
